// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants, request kinds and FSM states for the cache memory controller
package cache_pkg;
    localparam int ADDR_W     = 14;
    localparam int LINE_WORDS = 4;
    localparam int WORD_W     = 16;
    localparam int LINE_W     = 64;

    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_WB,
        REQ_WT,
        REQ_D,
        REQ_I
    } req_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XFER,
        ST_RESP
    } state_t;

    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                     input logic [1:0] idx);
        return line[idx*WORD_W +: WORD_W];
    endfunction
endpackage

// File: rtl/cache_mem_bank.sv
// rtl/cache_mem_bank.sv - single-port word RAM, synchronous write, registered read
module cache_mem_bank #(
    parameter int DEPTH_W = 12,
    parameter int WORD_W  = 16
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [DEPTH_W-1:0] i_addr,
    input  logic [WORD_W-1:0]  i_wdata,
    output logic [WORD_W-1:0]  o_rdata
);
    logic [WORD_W-1:0] r_mem [2**DEPTH_W];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/cache_mem_ctrl.sv
// rtl/cache_mem_ctrl.sv - memory-side responder for split I/D cache fills, write-backs and stores
module cache_mem_ctrl #(
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 4,
    parameter int DEPTH_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_line_addr,
    output logic [63:0]       i_line,
    output logic              i_rdy,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_line_addr,
    output logic [63:0]       d_line,
    output logic              d_rdy,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_line_addr,
    input  logic [63:0]       wb_line,
    output logic              wb_ack,
    input  logic              wt_req,
    input  logic [ADDR_W+1:0] wt_addr,
    input  logic [15:0]       wt_data,
    output logic              wt_ack,
    output logic              busy
);
    import cache_pkg::*;

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t              r_state;
    state_t              w_state_next;
    req_kind_t           r_kind;
    req_kind_t           w_grant;
    req_kind_t           w_masked;
    logic [ADDR_W-1:0]   r_line_addr;
    logic [ADDR_W-1:0]   w_grant_addr;
    logic [1:0]          r_wt_off;
    logic [1:0]          r_beat;
    logic [LINE_W-1:0]   r_wb_line;
    logic [LINE_W-1:0]   r_asm;
    logic [LINE_W-1:0]   r_i_line;
    logic [LINE_W-1:0]   r_d_line;
    logic [WORD_W-1:0]   r_wt_data;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                r_prev_resp;
    logic                w_last_beat;
    logic                w_is_fill;
    logic [LINE_W-1:0]   w_asm_next;

    logic                w_ram_we;
    logic [ADDR_W+1:0]   w_word_addr;
    logic [WORD_W-1:0]   w_ram_wdata;
    logic [WORD_W-1:0]   w_ram_rdata;
    logic                w_unused_addr;

    // A requester still holding req in the cycle after its pulse must not be served twice.
    assign w_masked = r_prev_resp ? r_kind : REQ_NONE;

    always_comb begin
        w_grant      = REQ_NONE;
        w_grant_addr = '0;
        if (wb_req && w_masked != REQ_WB) begin
            w_grant      = REQ_WB;
            w_grant_addr = wb_line_addr;
        end else if (wt_req && w_masked != REQ_WT) begin
            w_grant      = REQ_WT;
            w_grant_addr = wt_addr[ADDR_W+1:2];
        end else if (d_req && w_masked != REQ_D) begin
            w_grant      = REQ_D;
            w_grant_addr = d_line_addr;
        end else if (i_req && w_masked != REQ_I) begin
            w_grant      = REQ_I;
            w_grant_addr = i_line_addr;
        end
    end

    assign w_is_fill   = (r_kind == REQ_D) || (r_kind == REQ_I);
    assign w_last_beat = (r_kind == REQ_WT) || (r_beat == 2'd3);
    assign w_asm_next  = {w_ram_rdata, r_asm[LINE_W-1:WORD_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != ST_IDLE);
        i_rdy        = 1'b0;
        d_rdy        = 1'b0;
        wb_ack       = 1'b0;
        wt_ack       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant != REQ_NONE) begin
                    w_state_next = (LATENCY == 0) ? ST_XFER : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_last_beat) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
                i_rdy        = (r_kind == REQ_I);
                d_rdy        = (r_kind == REQ_D);
                wb_ack       = (r_kind == REQ_WB);
                wt_ack       = (r_kind == REQ_WT);
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Reads are issued one cycle ahead of the beat that consumes them, so word 0 is
    // fetched in IDLE/WAIT and the last word lands exactly as XFER ends.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_wdata = r_wt_data;
        w_word_addr = {r_line_addr, 2'b00};
        case (r_state)
            ST_IDLE: w_word_addr = {w_grant_addr, 2'b00};
            ST_XFER: begin
                if (r_kind == REQ_WB) begin
                    w_ram_we    = 1'b1;
                    w_ram_wdata = line_word(r_wb_line, r_beat);
                    w_word_addr = {r_line_addr, r_beat};
                end else if (r_kind == REQ_WT) begin
                    w_ram_we    = 1'b1;
                    w_word_addr = {r_line_addr, r_wt_off};
                end else begin
                    w_word_addr = {r_line_addr, r_beat + 2'd1};
                end
            end
            default: ;
        endcase
    end

    assign w_unused_addr = ^w_word_addr[ADDR_W+1:DEPTH_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kind      <= REQ_NONE;
            r_prev_resp <= 1'b0;
            r_beat      <= 2'd0;
            r_wait_cnt  <= '0;
            r_i_line    <= '0;
            r_d_line    <= '0;
        end else begin
            r_prev_resp <= (r_state == ST_RESP);
            case (r_state)
                ST_IDLE: begin
                    if (w_grant != REQ_NONE) begin
                        r_kind      <= w_grant;
                        r_line_addr <= w_grant_addr;
                        r_wt_off    <= wt_addr[1:0];
                        r_wb_line   <= wb_line;
                        r_wt_data   <= wt_data;
                        r_wait_cnt  <= CNT_W'(LATENCY - 1);
                        r_beat      <= 2'd0;
                    end
                end
                ST_WAIT: r_wait_cnt <= r_wait_cnt - 1'b1;
                ST_XFER: begin
                    r_beat <= r_beat + 2'd1;
                    if (w_is_fill) begin
                        r_asm <= w_asm_next;
                        if (r_beat == 2'd3) begin
                            if (r_kind == REQ_D) begin
                                r_d_line <= w_asm_next;
                            end else begin
                                r_i_line <= w_asm_next;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign i_line = r_i_line;
    assign d_line = r_d_line;

    cache_mem_bank #(
        .DEPTH_W(DEPTH_W),
        .WORD_W (WORD_W)
    ) u_bank (
        .clk    (clk),
        .i_we   (w_ram_we),
        .i_addr (w_word_addr[DEPTH_W-1:0]),
        .i_wdata(w_ram_wdata),
        .o_rdata(w_ram_rdata)
    );
endmodule

// File: tb/tb_cache_mem_ctrl.sv
// tb/tb_cache_mem_ctrl.sv - self-checking bench for cache_mem_ctrl (LATENCY=4 and LATENCY=0 builds)
module tb_cache_mem_ctrl;
    localparam int K_WB = 1;
    localparam int K_WT = 2;
    localparam int K_D  = 3;
    localparam int K_I  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_req, d_req, wb_req, wt_req;
    logic [13:0] i_line_addr, d_line_addr, wb_line_addr;
    logic [63:0] i_line, d_line, wb_line;
    logic        i_rdy, d_rdy, wb_ack, wt_ack, busy;
    logic [15:0] wt_addr, wt_data;

    logic        n_i_req, n_d_req, n_wb_req, n_wt_req;
    logic [13:0] n_i_line_addr, n_d_line_addr, n_wb_line_addr;
    logic [63:0] n_i_line, n_d_line, n_wb_line;
    logic        n_i_rdy, n_d_rdy, n_wb_ack, n_wt_ack, n_busy;
    logic [15:0] n_wt_addr, n_wt_data;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [4096];

    cache_mem_ctrl #(.ADDR_W(14), .LATENCY(4), .DEPTH_W(12)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_line_addr(i_line_addr), .i_line(i_line), .i_rdy(i_rdy),
        .d_req(d_req), .d_line_addr(d_line_addr), .d_line(d_line), .d_rdy(d_rdy),
        .wb_req(wb_req), .wb_line_addr(wb_line_addr), .wb_line(wb_line), .wb_ack(wb_ack),
        .wt_req(wt_req), .wt_addr(wt_addr), .wt_data(wt_data), .wt_ack(wt_ack),
        .busy(busy)
    );

    cache_mem_ctrl #(.ADDR_W(14), .LATENCY(0), .DEPTH_W(12)) dut_l0 (
        .clk(clk), .rst(rst),
        .i_req(n_i_req), .i_line_addr(n_i_line_addr), .i_line(n_i_line), .i_rdy(n_i_rdy),
        .d_req(n_d_req), .d_line_addr(n_d_line_addr), .d_line(n_d_line), .d_rdy(n_d_rdy),
        .wb_req(n_wb_req), .wb_line_addr(n_wb_line_addr), .wb_line(n_wb_line), .wb_ack(n_wb_ack),
        .wt_req(n_wt_req), .wt_addr(n_wt_addr), .wt_data(n_wt_data), .wt_ack(n_wt_ack),
        .busy(n_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mline(input logic [13:0] la);
        return {mem[{la[9:0], 2'd3}], mem[{la[9:0], 2'd2}], mem[{la[9:0], 2'd1}], mem[{la[9:0], 2'd0}]};
    endfunction

    function automatic logic pulse_of(input int k);
        case (k)
            K_WB:    return wb_ack;
            K_WT:    return wt_ack;
            K_D:     return d_rdy;
            default: return i_rdy;
        endcase
    endfunction

    task automatic drop_all();
        i_req = 1'b0; d_req = 1'b0; wb_req = 1'b0; wt_req = 1'b0;
    endtask

    task automatic model_wb(input logic [13:0] la, input logic [63:0] data);
        for (int o = 0; o < 4; o++) mem[{la[9:0], 2'(o)}] = data[o*16 +: 16];
    endtask

    // One isolated transaction on the LATENCY=4 build, checked against the model.
    task automatic op(input int kind, input logic [13:0] la, input logic [15:0] wa,
                      input logic [63:0] data, input string tag);
        int lat;
        logic [63:0] got;
        logic [3:0] pulses;
        lat = 0; got = '0; pulses = '0;
        case (kind)
            K_WB:    begin wb_req = 1'b1; wb_line_addr = la; wb_line = data; end
            K_WT:    begin wt_req = 1'b1; wt_addr = wa; wt_data = data[15:0]; end
            K_D:     begin d_req = 1'b1; d_line_addr = la; end
            default: begin i_req = 1'b1; i_line_addr = la; end
        endcase
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            step();
            if (pulse_of(kind)) begin
                lat    = c;
                got    = (kind == K_D) ? d_line : i_line;
                pulses = {wb_ack, wt_ack, d_rdy, i_rdy};
            end
        end
        drop_all();
        chk({tag, "_latency"}, 64'(lat), (kind == K_WT) ? 64'd6 : 64'd9);
        chk({tag, "_onehot"}, 64'($countones(pulses)), 64'd1);
        if (kind == K_WB) model_wb(la, data);
        if (kind == K_WT) mem[wa[11:0]] = data[15:0];
        if (kind == K_D || kind == K_I) chk({tag, "_line"}, got, mline(la));
        step();
        chk({tag, "_after"}, {59'd0, busy, wb_ack, wt_ack, d_rdy, i_rdy}, 64'd0);
        step();
    endtask

    task automatic op_l0(input int kind, input logic [13:0] la, input logic [15:0] wa,
                         input logic [63:0] data, output int lat, output logic [63:0] got);
        lat = 0; got = '0;
        case (kind)
            K_WB:    begin n_wb_req = 1'b1; n_wb_line_addr = la; n_wb_line = data; end
            K_WT:    begin n_wt_req = 1'b1; n_wt_addr = wa; n_wt_data = data[15:0]; end
            default: begin n_d_req = 1'b1; n_d_line_addr = la; end
        endcase
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            step();
            if ((kind == K_WB && n_wb_ack) || (kind == K_WT && n_wt_ack) || (kind == K_D && n_d_rdy)) begin
                lat = c;
                got = n_d_line;
            end
        end
        n_wb_req = 1'b0; n_wt_req = 1'b0; n_d_req = 1'b0;
        step();
        chk("l0_busy_after", {62'd0, n_busy, n_d_rdy}, 64'd0);
        step();
    endtask

    initial begin
        int t_wb, t_d, t_i, n_d, n_i, lat;
        logic [63:0] got_d, got_i, rdat, ldat;
        logic [13:0] pool [8];
        logic [13:0] la;
        logic [3:0] hi;
        logic [1:0] off;
        int kind;

        rst = 1'b1;
        drop_all();
        i_line_addr = '0; d_line_addr = '0; wb_line_addr = '0; wb_line = '0;
        wt_addr = '0; wt_data = '0;
        n_i_req = 1'b0; n_d_req = 1'b0; n_wb_req = 1'b0; n_wt_req = 1'b0;
        n_i_line_addr = '0; n_d_line_addr = '0; n_wb_line_addr = '0; n_wb_line = '0;
        n_wt_addr = '0; n_wt_data = '0;
        step();
        step();
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_pulses", {60'd0, i_rdy, d_rdy, wb_ack, wt_ack}, 64'd0);
        chk("reset_i_line", i_line, 64'd0);
        chk("reset_d_line", d_line, 64'd0);
        chk("reset_l0_busy", {63'd0, n_busy}, 64'd0);
        rst = 1'b0;
        step();

        // Preload words 0x100..0x103 = 1..4, then fetch as an icache line.
        op(K_WB, 14'h0040, 16'h0, 64'h0004_0003_0002_0001, "preload_wb");
        op(K_I, 14'h0040, 16'h0, 64'h0, "ifill_40");
        chk("ifill_40_value", i_line, 64'h0004_0003_0002_0001);

        // wb and d fill of the same line raised together: wb first, fill sees written data.
        wb_req = 1'b1; wb_line_addr = 14'h0000; wb_line = 64'hAAAA_BBBB_CCCC_DDDD;
        d_req = 1'b1; d_line_addr = 14'h0000;
        t_wb = 0; t_d = 0; got_d = '0;
        for (int c = 1; c <= 40 && t_d == 0; c++) begin
            step();
            if (wb_ack) begin
                if (t_wb == 0) t_wb = c;
                wb_req = 1'b0;
            end
            if (d_rdy) begin
                t_d = c; got_d = d_line; d_req = 1'b0;
            end
        end
        drop_all();
        model_wb(14'h0000, 64'hAAAA_BBBB_CCCC_DDDD);
        chk("wb_vs_d_wb_time", 64'(t_wb), 64'd9);
        chk("wb_vs_d_d_time", 64'(t_d), 64'd19);
        chk("wb_vs_d_line", got_d, 64'hAAAA_BBBB_CCCC_DDDD);
        step();
        step();

        // Write-through into word 0 of line 0, then refetch the line.
        op(K_WT, 14'h0, 16'h0000, 64'hFFFE, "wt_0");
        op(K_D, 14'h0000, 16'h0, 64'h0, "dfill_after_wt");
        chk("dfill_after_wt_value", d_line, 64'hAAAA_BBBB_CCCC_FFFE);

        // i and d together, both held through their pulses.
        i_req = 1'b1; i_line_addr = 14'h0040;
        d_req = 1'b1; d_line_addr = 14'h0000;
        t_d = 0; t_i = 0; n_d = 0; n_i = 0; got_d = '0; got_i = '0;
        for (int c = 1; c <= 40 && t_i == 0; c++) begin
            step();
            if (d_rdy) begin
                n_d++;
                if (t_d == 0) begin t_d = c; got_d = d_line; end
            end
            if (t_d != 0 && c == t_d + 2) d_req = 1'b0;
            if (i_rdy) begin
                n_i++; t_i = c; got_i = i_line;
            end
        end
        step();
        chk("id_no_dup", {62'd0, i_rdy, d_rdy}, 64'd0);
        drop_all();
        chk("id_d_time", 64'(t_d), 64'd9);
        chk("id_gap", 64'(t_i - t_d), 64'd10);
        chk("id_d_count", 64'(n_d), 64'd1);
        chk("id_d_line", got_d, mline(14'h0000));
        chk("id_i_line", got_i, mline(14'h0040));
        step();
        step();

        // Reset in the middle of a write-back's XFER, request held across it.
        rdat = {$urandom, $urandom};
        wb_req = 1'b1; wb_line_addr = 14'h0005; wb_line = rdat;
        n_d = 0;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (wb_ack) n_d++;
        end
        chk("rst_mid_busy_before", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        step();
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_pulses", {60'd0, i_rdy, d_rdy, wb_ack, wt_ack}, 64'd0);
        chk("rst_mid_no_early_ack", 64'(n_d), 64'd0);
        rst = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            step();
            if (wb_ack) lat = c;
        end
        drop_all();
        model_wb(14'h0005, rdat);
        chk("rst_mid_rearb_latency", 64'(lat), 64'd9);
        step();
        step();
        op(K_D, 14'h0005, 16'h0, 64'h0, "dfill_after_rst");

        // Randomized traffic over a small line pool, with aliased upper address bits.
        for (int p = 0; p < 8; p++) begin
            pool[p] = 14'($urandom_range(16, 1023));
            op(K_WB, pool[p], 16'h0, {$urandom, $urandom}, "pool_init");
        end
        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(K_WB, K_I);
            hi   = 4'($urandom_range(0, 15));
            off  = 2'($urandom_range(0, 3));
            la   = {hi, pool[$urandom_range(0, 7)][9:0]};
            op(kind, la, {la, off}, {$urandom, $urandom}, "rand");
        end

        // LATENCY=0 build.
        ldat = {$urandom, $urandom};
        op_l0(K_WB, 14'h0003, 16'h0, ldat, lat, got_d);
        chk("l0_wb_latency", 64'(lat), 64'd5);
        op_l0(K_D, 14'h0003, 16'h0, 64'h0, lat, got_d);
        chk("l0_d_latency", 64'(lat), 64'd5);
        chk("l0_d_line", got_d, ldat);
        op_l0(K_WT, 14'h0, 16'h000D, 64'h1234, lat, got_d);
        chk("l0_wt_latency", 64'(lat), 64'd2);
        ldat[31:16] = 16'h1234;
        op_l0(K_D, 14'h0003, 16'h0, 64'h0, lat, got_d);
        chk("l0_d_after_wt", got_d, ldat);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
